rom_wr_ctrl: RTL and testbench
==============================

ROM_WR_CTRL -- requirements
Module: rom_wr_ctrl

Interface
REQ-001 Parameter ADDR_WD, default 8, SHALL set the memory address width.
REQ-002 Parameter DATA_WD, default 8, SHALL set the memory data width.
REQ-003 Parameter NUM_WORDS, default 21, SHALL set the number of words written per load session (range 1..2^ADDR_WD).
REQ-004 Parameter SETUP_CYC, default 1, SHALL set the cycles of address/data setup before the WE_bar strobe (minimum 1).
REQ-005 Parameter PULSE_CYC, default 2, SHALL set the WE_bar low width in cycles (minimum 1).
REQ-006 Parameter HOLD_CYC, default 1, SHALL set the cycles of address/data hold after the strobe (minimum 1).
REQ-007 Ports SHALL be: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high reset.
REQ-008 Ports SHALL be: start  in  1  begin session; start_addr  in  ADDR_WD  session base address; abort  in  1  end session early.
REQ-009 Ports SHALL be: in_vld  in  1  data beat valid; in_data  in  DATA_WD  data beat; in_rdy  out  1  beat accepted when in_vld&in_rdy.
REQ-010 Ports SHALL be: mem_addr  out  ADDR_WD; mem_wr_data  out  DATA_WD; CE_bar, OE_bar, WE_bar  out  1 each, active-low memory strobes.
REQ-011 Ports SHALL be: busy  out  1  session active; done  out  1  one-cycle completion pulse; wr_count  out  ADDR_WD+1  words written this session.

Function
REQ-012 FSM states SHALL be IDLE, WAIT_DATA, SETUP, PULSE, HOLD, DONE; all outputs registered.
REQ-013 IDLE: start=1 -> latch start_addr into mem_addr, clear wr_count, go WAIT_DATA; start is ignored in all other states.
REQ-014 WAIT_DATA: in_rdy=1, CE_bar=1, WE_bar=1; on in_vld=1 latch in_data into mem_wr_data, go SETUP; in_rdy SHALL be 0 in every other state.
REQ-015 SETUP: CE_bar=0, WE_bar=1 for exactly SETUP_CYC cycles, then PULSE.
REQ-016 PULSE: CE_bar=0, WE_bar=0 for exactly PULSE_CYC cycles, then HOLD.
REQ-017 HOLD: CE_bar=0, WE_bar=1 for exactly HOLD_CYC cycles; mem_addr and mem_wr_data SHALL stay stable from SETUP entry through HOLD exit.
REQ-018 On HOLD exit: wr_count +1, mem_addr +1 modulo 2^ADDR_WD (0xFF wraps to 0x00); if new wr_count==NUM_WORDS go DONE, else WAIT_DATA.
REQ-019 DONE: done=1 for one cycle, then IDLE; wr_count holds its final value until the next start.
REQ-020 OE_bar SHALL be 1 at all times (write-only master).
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 abort in WAIT_DATA SHALL go to IDLE next cycle with no done pulse; a beat offered in that same cycle SHALL NOT be accepted.
REQ-023 abort in SETUP/PULSE/HOLD SHALL be latched; the current write SHALL complete its full timing; the FSM then goes IDLE (no done pulse), with wr_count including that write.
REQ-024 abort and the final HOLD exit in the same cycle SHALL give IDLE with no done pulse.
REQ-025 Per-write occupancy SHALL be SETUP_CYC+PULSE_CYC+HOLD_CYC cycles plus 1 WAIT_DATA acceptance cycle minimum.

Reset
REQ-026 reset=1 SHALL asynchronously force: state IDLE, CE_bar=1, OE_bar=1, WE_bar=1, in_rdy=0, busy=0, done=0, mem_addr=0, mem_wr_data=0, wr_count=0.
REQ-027 reset asserted mid-write SHALL deassert WE_bar and CE_bar immediately, without waiting for a clock edge; no partial session state SHALL survive.

Verification
REQ-028 Defaults, start_addr=0x00, 21 beats 0x10..0x24 always valid -> 21 strobes, each CE_bar low 4 cycles, WE_bar low 2 cycles; a memory model holds addr k = 0x10+k; done pulses once; wr_count=21.
REQ-029 start_addr=0xFE, NUM_WORDS=4 -> writes at 0xFE, 0xFF, 0x00, 0x01; done after the 4th write.
REQ-030 in_vld gapped (valid 1 of 5 cycles) -> in_rdy high only in WAIT_DATA; no strobe while waiting; data order preserved.
REQ-031 abort during the PULSE of the 3rd write -> 3rd write completes, busy falls after HOLD, wr_count=3, no done pulse; a later start begins a fresh session.
REQ-032 reset pulsed while WE_bar=0 -> WE_bar/CE_bar high within the same cycle, all outputs at reset values, start after release works normally.
REQ-033 start held high for the entire session -> exactly one session; done at the end; the following IDLE cycle with start=1 begins a new session.

Source files
------------

// File: rtl/rom_wr_ctrl_if.sv
// Bus bundle for rom_wr_ctrl: session control, data-beat handshake,
// memory strobes and status. The controller takes the master side.
interface rom_wr_ctrl_if #(
    parameter int ADDR_WD = 8,
    parameter int DATA_WD = 8
);
    logic               start;
    logic [ADDR_WD-1:0] start_addr;
    logic               abort;
    logic               in_vld;
    logic [DATA_WD-1:0] in_data;
    logic               in_rdy;
    logic [ADDR_WD-1:0] mem_addr;
    logic [DATA_WD-1:0] mem_wr_data;
    logic               CE_bar;
    logic               OE_bar;
    logic               WE_bar;
    logic               busy;
    logic               done;
    logic [ADDR_WD:0]   wr_count;

    // Controller view: drives the memory bus and status.
    modport master (
        input  start, start_addr, abort, in_vld, in_data,
        output in_rdy, mem_addr, mem_wr_data, CE_bar, OE_bar, WE_bar,
               busy, done, wr_count
    );

    // Environment view: issues sessions and data beats.
    modport slave (
        output start, start_addr, abort, in_vld, in_data,
        input  in_rdy, mem_addr, mem_wr_data, CE_bar, OE_bar, WE_bar,
               busy, done, wr_count
    );
endinterface

// File: rtl/rom_wr_ctrl.sv
// Write controller for an asynchronous SRAM/EEPROM-style memory.
// A session writes NUM_WORDS beats at consecutive addresses, each with a
// setup / WE_bar pulse / hold sequence. All outputs are registered; the
// strobes are decoded from the next state so they line up with the state.
module rom_wr_ctrl #(
    parameter int ADDR_WD   = 8,
    parameter int DATA_WD   = 8,
    parameter int NUM_WORDS = 21,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic          clk,
    input  logic          reset,
    rom_wr_ctrl_if.master bus
);

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_WD:0] LAST_WORD  = (ADDR_WD + 1)'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_SETUP, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic               abort_q, abort_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [DATA_WD-1:0] data_q, data_d;
    logic [ADDR_WD:0]   cnt_q, cnt_d;
    logic [ADDR_WD:0]   cnt_inc;
    logic               ce_bar_q, ce_bar_d;
    logic               we_bar_q, we_bar_d;
    logic               in_rdy_q, in_rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        abort_d = abort_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WAIT_DATA;
                    addr_d  = bus.start_addr;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end
            end
            S_WAIT_DATA: begin
                // abort wins over a beat offered in the same cycle
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.in_vld) begin
                    data_d  = bus.in_data;
                    cyc_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                abort_d = abort_q | bus.abort;
                if (cyc_q == SETUP_LAST) begin
                    cyc_d   = '0;
                    state_d = S_PULSE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_PULSE: begin
                abort_d = abort_q | bus.abort;
                if (cyc_q == PULSE_LAST) begin
                    cyc_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_HOLD: begin
                abort_d = abort_q | bus.abort;
                if (cyc_q == HOLD_LAST) begin
                    // write is complete; abort (latched or late) suppresses done
                    cyc_d  = '0;
                    cnt_d  = cnt_inc;
                    addr_d = addr_q + 1'b1;
                    if (abort_q || bus.abort)   state_d = S_IDLE;
                    else if (cnt_inc == LAST_WORD) state_d = S_DONE;
                    else                        state_d = S_WAIT_DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ce_bar_d = !(state_d == S_SETUP || state_d == S_PULSE || state_d == S_HOLD);
        we_bar_d = (state_d != S_PULSE);
        in_rdy_d = (state_d == S_WAIT_DATA);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    // State and output registers; reset drops the strobes without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            abort_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ce_bar_q <= 1'b1;
            we_bar_q <= 1'b1;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            abort_q  <= abort_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ce_bar_q <= ce_bar_d;
            we_bar_q <= we_bar_d;
            in_rdy_q <= in_rdy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = data_q;
    assign bus.CE_bar      = ce_bar_q;
    assign bus.OE_bar      = 1'b1;
    assign bus.WE_bar      = we_bar_q;
    assign bus.in_rdy      = in_rdy_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wr_count    = cnt_q;

endmodule

// File: tb/tb_rom_wr_ctrl.sv
// Randomized self-checking bench for rom_wr_ctrl. A bus monitor turns
// strobe activity into a write log and memory image; each session task
// predicts the write list from start address and offered beats.
module tb_rom_wr_ctrl;
    localparam int NW = 21;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    rom_wr_ctrl_if #(.ADDR_WD(8), .DATA_WD(8)) ifc ();
    rom_wr_ctrl_if #(.ADDR_WD(8), .DATA_WD(8)) ifc4 ();

    rom_wr_ctrl #(.ADDR_WD(8), .DATA_WD(8)) u0 (.clk(clk), .reset(rst), .bus(ifc));
    rom_wr_ctrl #(.ADDR_WD(8), .DATA_WD(8), .NUM_WORDS(4)) u1 (.clk(clk), .reset(rst), .bus(ifc4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bus monitor for u0: strobe timing, invariants, write log, memory image
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] mem [256];

    initial begin
        int ce_run, we_run;
        logic [7:0] la, ld;
        ce_run = 0; we_run = 0; la = '0; ld = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ce_run = 0; we_run = 0;
            end else begin
                n_checks++;
                if (!ifc.OE_bar || (!ifc.WE_bar && ifc.CE_bar) ||
                    (ifc.in_rdy && (!ifc.CE_bar || !ifc.busy))) begin
                    n_errors++;
                    $display("FAIL bus_invariant: got OE=%b WE=%b CE=%b rdy=%b busy=%b", ifc.OE_bar,
                             ifc.WE_bar, ifc.CE_bar, ifc.in_rdy, ifc.busy);
                end
                if (!ifc.CE_bar) begin
                    if (ce_run == 0) begin
                        la = ifc.mem_addr; ld = ifc.mem_wr_data;
                    end else begin
                        n_checks++;
                        if (ifc.mem_addr !== la || ifc.mem_wr_data !== ld) begin
                            n_errors++;
                            $display("FAIL addr_data_stable: got %h/%h expected %h/%h",
                                     ifc.mem_addr, ifc.mem_wr_data, la, ld);
                        end
                    end
                    if (!ifc.WE_bar) begin
                        n_checks++;
                        if (ce_run < 1 || ce_run > 2) begin
                            n_errors++;
                            $display("FAIL we_position: got CE cycle %0d expected 1..2", ce_run);
                        end
                        we_run++;
                    end
                    ce_run++;
                end else if (ce_run > 0) begin
                    n_checks++;
                    if (ce_run != 4 || we_run != 2) begin
                        n_errors++;
                        $display("FAIL strobe_width: got CE %0d WE %0d expected CE 4 WE 2", ce_run, we_run);
                    end
                    wa_q.push_back(la);
                    wd_q.push_back(ld);
                    mem[la] = ld;
                    ce_run = 0; we_run = 0;
                end
            end
        end
    end

    // One session on u0. mode: 0 none, 1 abort in PULSE of write k,
    // 2 abort in WAIT_DATA after k writes (beat offered), 3 abort in HOLD of write k.
    task automatic run_session(input logic [7:0] sa, input bit incr, input int gap,
                               input int mode, input int k, input bit hold);
        logic [7:0] beats [NW];
        logic [7:0] ea;
        int base, bi, wdone, dones, cyc, nexp, got;
        bit fin, aborted, we_seen, prev_ce, acc;
        for (int i = 0; i < NW; i++) beats[i] = incr ? 8'(8'h10 + i) : 8'($urandom);
        nexp = (mode == 0) ? NW : k;
        base = wa_q.size();
        bi = 0; wdone = 0; dones = 0; cyc = 0;
        fin = 0; aborted = 0; we_seen = 0; prev_ce = 1;
        ifc.start = 1; ifc.start_addr = sa; ifc.in_vld = 0; ifc.abort = 0;
        tick;
        if (!hold) ifc.start = 0;
        while (!fin && cyc < 3000) begin
            if (ifc.done) dones++;
            if (!prev_ce && ifc.CE_bar) wdone++;
            prev_ce = ifc.CE_bar;
            if (!ifc.WE_bar) we_seen = 1;
            if (ifc.CE_bar) we_seen = 0;
            if (!ifc.busy) begin
                fin = 1;
            end else begin
                ifc.abort  = 0;
                ifc.in_vld = (gap <= 1) || ($urandom_range(0, gap - 1) == 0);
                ifc.in_data = (bi < NW) ? beats[bi] : 8'($urandom);
                if (!aborted) begin
                    if (mode == 1 && !ifc.WE_bar && wdone == k - 1) begin
                        ifc.abort = 1; aborted = 1;
                    end
                    if (mode == 2 && ifc.in_rdy && wdone == k) begin
                        ifc.abort = 1; ifc.in_vld = 1; aborted = 1;
                    end
                    if (mode == 3 && !ifc.CE_bar && ifc.WE_bar && we_seen && wdone == k - 1) begin
                        ifc.abort = 1; aborted = 1;
                    end
                end
                acc = ifc.in_vld && ifc.in_rdy && !ifc.abort;
                tick;
                cyc++;
                if (acc) bi++;
            end
        end
        ifc.abort = 0; ifc.in_vld = 0;
        if (!fin) begin
            n_checks++; n_errors++;
            $display("FAIL session_timeout: got busy after %0d cycles expected idle", cyc);
        end
        @(negedge clk);
        #1;
        got = wa_q.size() - base;
        n_checks++;
        if (got != nexp) begin
            n_errors++;
            $display("FAIL write_count: got %0d expected %0d", got, nexp);
        end
        for (int i = 0; i < got && i < nexp; i++) begin
            ea = sa + 8'(i);
            n_checks++;
            if (wa_q[base + i] !== ea || wd_q[base + i] !== beats[i]) begin
                n_errors++;
                $display("FAIL write_%0d: got %h:%h expected %h:%h", i, wa_q[base + i],
                         wd_q[base + i], ea, beats[i]);
            end
        end
        n_checks++;
        if (ifc.wr_count !== 9'(nexp)) begin
            n_errors++;
            $display("FAIL wr_count: got %0d expected %0d", ifc.wr_count, nexp);
        end
        n_checks++;
        if (dones != ((mode == 0) ? 1 : 0)) begin
            n_errors++;
            $display("FAIL done_pulses: got %0d expected %0d", dones, (mode == 0) ? 1 : 0);
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({ifc.CE_bar, ifc.OE_bar, ifc.WE_bar, ifc.in_rdy, ifc.busy, ifc.done} !== 6'b111000) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b expected 111000",
                     {ifc.CE_bar, ifc.OE_bar, ifc.WE_bar, ifc.in_rdy, ifc.busy, ifc.done});
        end
        n_checks++;
        if (ifc.mem_addr !== 8'h00 || ifc.mem_wr_data !== 8'h00 || ifc.wr_count !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_regs: got %h/%h/%0d expected 0/0/0", ifc.mem_addr,
                     ifc.mem_wr_data, ifc.wr_count);
        end
        rst = 0;
        tick;
        n_checks++;
        if (ifc.busy !== 1'b0 || ifc.CE_bar !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy=%b CE=%b expected 0/1", ifc.busy, ifc.CE_bar);
        end
    endtask

    task automatic test_basic;
        int bad;
        run_session(8'h00, 1, 1, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== 8'(8'h10 + i)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL mem_image: got %0d bad words expected 0", bad);
        end
    endtask

    task automatic test_random;
        repeat (3) run_session(8'($urandom), 0, $urandom_range(1, 3), 0, 0, 0);
    endtask

    task automatic test_gapped;
        run_session(8'($urandom), 0, 5, 0, 0, 0);
    endtask

    task automatic test_abort;
        run_session(8'($urandom), 0, 1, 1, 3, 0);
        run_session(8'($urandom), 0, 2, 0, 0, 0);
        run_session(8'($urandom), 0, 1, 2, 5, 0);
        run_session(8'($urandom), 0, 1, 3, NW, 0);
    endtask

    task automatic test_reset_mid_write;
        int cyc;
        ifc.start = 1; ifc.start_addr = 8'($urandom); ifc.in_vld = 1; ifc.in_data = 8'h5A;
        tick;
        ifc.start = 0;
        cyc = 0;
        while (ifc.WE_bar !== 1'b0 && cyc < 50) begin
            ifc.in_data = 8'($urandom_range(1, 255));
            tick;
            cyc++;
        end
        n_checks++;
        if (ifc.WE_bar !== 1'b0) begin
            n_errors++;
            $display("FAIL reach_pulse: got WE=%b expected 0", ifc.WE_bar);
        end
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (ifc.WE_bar !== 1'b1 || ifc.CE_bar !== 1'b1) begin
            n_errors++;
            $display("FAIL async_strobe_release: got WE=%b CE=%b expected 1/1", ifc.WE_bar, ifc.CE_bar);
        end
        n_checks++;
        if ({ifc.in_rdy, ifc.busy, ifc.done} !== 3'b000 || ifc.mem_addr !== 8'h00 ||
            ifc.mem_wr_data !== 8'h00 || ifc.wr_count !== 9'd0) begin
            n_errors++;
            $display("FAIL async_reset_regs: got %b %h/%h/%0d expected 000 0/0/0",
                     {ifc.in_rdy, ifc.busy, ifc.done}, ifc.mem_addr, ifc.mem_wr_data, ifc.wr_count);
        end
        ifc.in_vld = 0;
        tick;
        rst = 0;
        tick;
        run_session(8'($urandom), 0, 1, 0, 0, 0);
    endtask

    task automatic test_start_held;
        run_session(8'($urandom), 0, 1, 0, 0, 1);
        tick;
        n_checks++;
        if (ifc.busy !== 1'b1 || ifc.in_rdy !== 1'b1 || ifc.wr_count !== 9'd0) begin
            n_errors++;
            $display("FAIL restart_held: got busy=%b rdy=%b cnt=%0d expected 1/1/0",
                     ifc.busy, ifc.in_rdy, ifc.wr_count);
        end
        ifc.start = 0; ifc.abort = 1; ifc.in_vld = 1; ifc.in_data = 8'hC3;
        tick;
        ifc.abort = 0; ifc.in_vld = 0;
        n_checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.CE_bar !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_wait_idle: got busy=%b done=%b CE=%b expected 0/0/1",
                     ifc.busy, ifc.done, ifc.CE_bar);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] beats [4];
        logic [7:0] wa[$];
        logic [7:0] wd[$];
        logic [7:0] la, ld, ea;
        int dones, cyc, bi;
        bit prev_ce, fin, acc;
        for (int i = 0; i < 4; i++) beats[i] = 8'($urandom);
        dones = 0; cyc = 0; bi = 0; prev_ce = 1; fin = 0; la = '0; ld = '0;
        ifc4.start = 1; ifc4.start_addr = 8'hFE;
        tick;
        ifc4.start = 0;
        while (!fin && cyc < 500) begin
            if (ifc4.done) dones++;
            if (!ifc4.CE_bar) begin
                la = ifc4.mem_addr; ld = ifc4.mem_wr_data;
            end else if (!prev_ce) begin
                wa.push_back(la); wd.push_back(ld);
            end
            prev_ce = ifc4.CE_bar;
            if (!ifc4.busy) begin
                fin = 1;
            end else begin
                ifc4.in_vld = 1;
                ifc4.in_data = (bi < 4) ? beats[bi] : 8'h00;
                acc = ifc4.in_rdy;
                tick;
                cyc++;
                if (acc) bi++;
            end
        end
        ifc4.in_vld = 0;
        n_checks++;
        if (!fin || wa.size() != 4) begin
            n_errors++;
            $display("FAIL wrap_count: got %0d writes fin=%b expected 4", wa.size(), fin);
        end
        for (int i = 0; i < wa.size() && i < 4; i++) begin
            ea = 8'hFE + 8'(i);
            n_checks++;
            if (wa[i] !== ea || wd[i] !== beats[i]) begin
                n_errors++;
                $display("FAIL wrap_write_%0d: got %h:%h expected %h:%h", i, wa[i], wd[i], ea, beats[i]);
            end
        end
        n_checks++;
        if (ifc4.wr_count !== 9'd4 || dones != 1) begin
            n_errors++;
            $display("FAIL wrap_done: got cnt=%0d dones=%0d expected 4/1", ifc4.wr_count, dones);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 0;
        ifc.start = 0; ifc.start_addr = '0; ifc.abort = 0; ifc.in_vld = 0; ifc.in_data = '0;
        ifc4.start = 0; ifc4.start_addr = '0; ifc4.abort = 0; ifc4.in_vld = 0; ifc4.in_data = '0;
        #2;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_random;
        test_gapped;
        test_abort;
        test_reset_mid_write;
        test_start_held;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
